sync_fifo_lvl: RTL and testbench
================================

# sync_fifo_lvl

Parametrised synchronous FIFO for the UART/Wishbone bridge, replacing the fixed 8-deep FIFO on both RX and TX paths. It uses all 2**DEPL2 entries, and exposes a fill level plus almost-full and almost-empty thresholds for Wishbone status and interrupt logic. It offers a registered-read mode and a first-word-fall-through (FWFT) mode, and keeps sticky overflow/underflow error flags.

## Interface
- DATA_WID, 8: data width in bits.
- DEPL2, 3: log2 of depth. DEPTH = 2**DEPL2 is a derived localparam, not overridable.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.
- AF_THRESH, DEPTH-1: almost_full asserts when level >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when level <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset, synchronous, active-low.
- push  in  1  write request.
- pop  in  1  read request.
- data_in  in  DATA_WID  write data.
- clr_err  in  1  clears overflow and underflow.
- data_out  out  DATA_WID  read data.
- full, empty  out  1  occupancy flags.
- almost_full, almost_empty  out  1  threshold flags.
- level  out  DEPL2+1  number of stored entries, 0..DEPTH.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Read and write pointers are DEPL2+1 bits wide. The low DEPL2 bits address storage; the MSB distinguishes full from empty.
- Pointers wrap naturally modulo 2*DEPTH.
- level = wr_ptr - rd_ptr, computed modulo 2**(DEPL2+1).
- empty = (level == 0). full = (level == DEPTH).
- Flags and level derive only from registered pointers and are glitch-free.
- pop_ok = pop && !empty.
- push_ok = push && (!full || pop_ok). Push while full is accepted only when a pop is accepted in the same cycle. Storage at that slot is read before it is overwritten.
- Push while empty with a simultaneous pop: push accepted, pop rejected.
- overflow sets on push && !push_ok. underflow sets on pop && empty.
- clr_err clears both error flags. A set event in the same cycle wins over clr_err.
- Rejected operations change no pointer and no data.
- FWFT=0: data_out loads the head entry on pop_ok and holds otherwise.
- FWFT=1: data_out continuously presents the head entry when !empty, and 0 when empty. pop acknowledges the presented word.

## Timing
- Reset (nrst low at an edge) gives: pointers 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, data_out 0. Storage contents are not reset.
- Reset asserted mid-operation discards all contents within one cycle. A push/pop in the reset cycle is ignored.
- push_ok at edge N: the word is stored at N. level, empty and the almost flags reflect it after edge N.
- FWFT=0: data_out is valid after the edge at which pop_ok occurred (1-cycle latency).
- FWFT=1: a word pushed into an empty FIFO at edge N appears on data_out after edge N (0 cycles after empty deasserts). After a pop_ok, the next word appears after the same edge.
- Simultaneous push_ok and pop_ok leave level unchanged.
- Throughput is one push and one pop per cycle sustained, including at full.

## Structure
- Shared package uart_wb_pkg holds FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1 for the FWFT parameter, plus the default DATA_WID.
- One sub-module, fifo_ram: DEPTH x DATA_WID array with synchronous write and asynchronous read, parametrised by DATA_WID and DEPL2.
- Pointer, flag, error and output logic live in sync_fifo_lvl.

## Test plan
- Reset, then 8 pushes of 0x10..0x17 (DEPL2=3): level 1..8 after each push. full=1 after the 8th, almost_full=1 from level 7, empty=0 after the first push.
- Full FIFO, push 0xAA alone: overflow=1, level stays 8, and popping all returns 0x10..0x17. clr_err with no error event clears overflow the next cycle.
- Full FIFO, push 0x55 together with pop: data_out=0x10 (FWFT=0, next cycle), level stays 8, and 0x55 is popped last.
- Empty FIFO, pop alone: underflow=1, data_out unchanged. Push 0x33 together with pop: level=1, underflow=1.
- FWFT=1: push 0x42 into empty, so data_out=0x42 on the following cycle without a pop. Pop, so data_out=0 and empty=1.
- 20 pushes/pops interleaved across pointer wrap, then nrst low mid-stream: level=0, empty=1, data_out=0 the next cycle, and data order was preserved before reset.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// Shared constants for the UART/Wishbone bridge FIFOs.
package uart_wb_pkg;

  // Values for the FWFT parameter of sync_fifo_lvl.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Default data width of the bridge FIFOs (one UART character).
  localparam int DEF_DATA_WID = 8;

endpackage : uart_wb_pkg

// File: rtl/sync_fifo_lvl_ram.sv
// Storage array for sync_fifo_lvl: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_ram #(
  parameter int DATA_WID = 8,
  parameter int DEPL2    = 3
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DEPL2-1:0]    waddr,
  input  logic [DATA_WID-1:0] wdata,
  input  logic [DEPL2-1:0]    raddr,
  output logic [DATA_WID-1:0] rdata
);

  localparam int DEPTH = 2 ** DEPL2;

  logic [DATA_WID-1:0] mem [DEPTH];

  // Write port: store one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is combinational so a same-cycle write to the head slot is
  // seen by the reader as the old value (read-before-write).
  assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/sync_fifo_lvl.sv
// Parametrised synchronous FIFO with fill level, almost-full/almost-empty
// thresholds, registered-read or first-word-fall-through output, and sticky
// overflow/underflow flags.
//
// Handshake: push and pop are requests sampled on the rising edge. A pop is
// accepted when the FIFO is not empty. A push is accepted when the FIFO is
// not full, or when it is full and a pop is accepted in the same cycle.
// Rejected requests change neither pointers nor data; they only raise the
// matching sticky error flag (set beats clr_err in the same cycle).
module sync_fifo_lvl
  import uart_wb_pkg::*;
#(
  parameter int DATA_WID  = DEF_DATA_WID,
  parameter int DEPL2     = 3,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AF_THRESH = (2 ** DEPL2) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_WID-1:0] data_in,
  input  logic                clr_err,
  output logic [DATA_WID-1:0] data_out,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [DEPL2:0]      level,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 2 ** DEPL2;

  // Level values in pointer width; DEPTH itself needs the extra MSB.
  localparam logic [DEPL2:0] PTR_ONE   = 1;
  localparam logic [DEPL2:0] DEPTH_LVL = {1'b1, {DEPL2{1'b0}}};
  localparam logic [DEPL2:0] AF_LVL    = AF_THRESH[DEPL2:0];
  localparam logic [DEPL2:0] AE_LVL    = AE_THRESH[DEPL2:0];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [DEPL2:0]      wr_ptr;
  logic [DEPL2:0]      rd_ptr;
  logic                pop_ok;
  logic                push_ok;
  logic [DATA_WID-1:0] head_data;

  // Occupancy decodes purely from the registered pointers.
  assign level        = wr_ptr - rd_ptr;
  assign empty        = (level == '0);
  assign full         = (level == DEPTH_LVL);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // Accept logic: a pop frees the slot a same-cycle push at full reuses.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  fifo_ram #(
    .DATA_WID (DATA_WID),
    .DEPL2    (DEPL2)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok && nrst),
    .waddr (wr_ptr[DEPL2-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[DEPL2-1:0]),
    .rdata (head_data)
  );

  // Pointer registers advance only on accepted operations.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky error flags: a new error event takes priority over clr_err.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown whenever present; zero when nothing is stored.
      assign data_out = empty ? '0 : head_data;
    end else begin : g_std
      logic [DATA_WID-1:0] dout_q;

      // Registered read: capture the head word on an accepted pop, hold otherwise.
      always_ff @(posedge clk) begin
        if (!nrst) begin
          dout_q <= '0;
        end else if (pop_ok) begin
          dout_q <= head_data;
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule : sync_fifo_lvl

// File: tb/tb_sync_fifo_lvl.sv
// Directed self-checking bench for sync_fifo_lvl. Instance u_std uses the
// registered-read mode; u_fwft uses first-word-fall-through.
`timescale 1ns/1ps
module tb_sync_fifo_lvl;
  import uart_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       push, pop, clr_err;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] level;

  logic       push1, pop1, clr_err1;
  logic [7:0] data_in1;
  logic [7:0] data_out1;
  logic       full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [3:0] level1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  sync_fifo_lvl #(
    .DATA_WID (8), .DEPL2 (3), .FWFT (FIFO_MODE_STD), .AF_THRESH (7), .AE_THRESH (1)
  ) u_std (
    .clk (clk), .nrst (nrst), .push (push), .pop (pop), .data_in (data_in),
    .clr_err (clr_err), .data_out (data_out), .full (full), .empty (empty),
    .almost_full (almost_full), .almost_empty (almost_empty), .level (level),
    .overflow (overflow), .underflow (underflow)
  );

  sync_fifo_lvl #(
    .DATA_WID (8), .DEPL2 (3), .FWFT (FIFO_MODE_FWFT), .AF_THRESH (7), .AE_THRESH (1)
  ) u_fwft (
    .clk (clk), .nrst (nrst), .push (push1), .pop (pop1), .data_in (data_in1),
    .clr_err (clr_err1), .data_out (data_out1), .full (full1), .empty (empty1),
    .almost_full (almost_full1), .almost_empty (almost_empty1), .level (level1),
    .overflow (overflow1), .underflow (underflow1)
  );

  // ---------------- driver tasks ----------------
  // Advance one rising edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    push1 = 1'b0; pop1 = 1'b0; clr_err1 = 1'b0;
  endtask

  // Fill u_std with 0x10..0x17 without checking (setup only).
  task automatic fill_std();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; data_in = 8'h10 + 8'(i);
      step();
    end
    push = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); data_in = 8'h00; data_in1 = 8'h00;
    nrst = 1'b0;
    step(); step();
    nrst = 1'b1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    checks++; if (data_out1 !== 8'h00 || empty1 !== 1'b1) begin errors++; $display("FAIL reset_fwft got=%h/%b exp=00/1", data_out1, empty1); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; data_in = 8'h10 + 8'(i);
      step();
      checks++; if (level !== 4'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
      checks++; if (full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 7)); end
      checks++; if (almost_full !== (i + 1 >= 7)) begin errors++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 7)); end
      checks++; if (almost_empty !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (i + 1 <= 1)); end
    end
    push = 1'b0;
  endtask

  task automatic test_overflow();
    push = 1'b1; data_in = 8'hAA;
    step();
    push = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got=%0d exp=8", level); end
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      step();
      checks++; if (data_out !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_pop[%0d] got=%h exp=%h", i, data_out, 8'h10 + 8'(i)); end
      checks++; if (level !== 4'(7 - i)) begin errors++; $display("FAIL ovf_pop_level[%0d] got=%0d exp=%0d", i, level, 7 - i); end
    end
    pop = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_pop [8];
    fill_std();
    push = 1'b1; pop = 1'b1; data_in = 8'h55;
    step();
    push = 1'b0; pop = 1'b0;
    checks++; if (data_out !== 8'h10) begin errors++; $display("FAIL fpp_dout got=%h exp=10", data_out); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL fpp_level got=%0d exp=8", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    exp_pop = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      step();
      checks++; if (data_out !== exp_pop[i]) begin errors++; $display("FAIL fpp_pop[%0d] got=%h exp=%h", i, data_out, exp_pop[i]); end
    end
    pop = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got=%b exp=1", underflow); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL udf_dout got=%h exp=55", data_out); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL udf_level got=%0d exp=0", level); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    push = 1'b1; pop = 1'b1; data_in = 8'h33; clr_err = 1'b1;
    step();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL udf_pp_level got=%0d exp=1", level); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_pp_flag got=%b exp=1", underflow); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL udf_pp_dout got=%h exp=55", data_out); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL udf_pop33 got=%h exp=33", data_out); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_fwft();
    push1 = 1'b1; data_in1 = 8'h42;
    step();
    push1 = 1'b0;
    checks++; if (data_out1 !== 8'h42) begin errors++; $display("FAIL fwft_show got=%h exp=42", data_out1); end
    checks++; if (empty1 !== 1'b0) begin errors++; $display("FAIL fwft_nempty got=%b exp=0", empty1); end
    pop1 = 1'b1;
    step();
    pop1 = 1'b0;
    checks++; if (data_out1 !== 8'h00) begin errors++; $display("FAIL fwft_zero got=%h exp=00", data_out1); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fwft_empty got=%b exp=1", empty1); end
    push1 = 1'b1; data_in1 = 8'h61;
    step();
    data_in1 = 8'h62;
    step();
    push1 = 1'b0;
    checks++; if (data_out1 !== 8'h61) begin errors++; $display("FAIL fwft_head got=%h exp=61", data_out1); end
    pop1 = 1'b1;
    step();
    pop1 = 1'b0;
    checks++; if (data_out1 !== 8'h62) begin errors++; $display("FAIL fwft_next got=%h exp=62", data_out1); end
    checks++; if (level1 !== 4'd1) begin errors++; $display("FAIL fwft_level got=%0d exp=1", level1); end
  endtask

  task automatic test_wrap_reset();
    bit p_push, p_pop, pop_acc, push_acc;
    logic [7:0] exp_d;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      p_push = (i % 3) != 2;
      p_pop  = (i % 2) == 1;
      pop_acc  = p_pop && (exp_q.size() > 0);
      push_acc = p_push && (exp_q.size() < 8 || pop_acc);
      push = p_push; pop = p_pop; data_in = 8'h80 + 8'(i);
      exp_d = 8'h00;
      if (pop_acc) exp_d = exp_q.pop_front();
      if (push_acc) exp_q.push_back(8'h80 + 8'(i));
      step();
      if (pop_acc) begin
        checks++; if (data_out !== exp_d) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, data_out, exp_d); end
      end
      checks++; if (level !== 4'(exp_q.size())) begin errors++; $display("FAIL wrap_level[%0d] got=%0d exp=%0d", i, level, exp_q.size()); end
    end
    // Reset mid-stream with requests still active.
    push = 1'b1; pop = 1'b1; data_in = 8'hEE;
    nrst = 1'b0;
    step();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h exp=00", data_out); end
    nrst = 1'b1; push = 1'b0; pop = 1'b0;
    step();
    checks++; if (level !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL rst_hold got=%0d/%b exp=0/0", level, full); end
    exp_q.delete();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_fwft();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo_lvl
